// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch into a DEPTH-entry in-order buffer with redirect/flush.
// Latency: a response accepted in cycle t is presented on if_id in cycle t+1 (show-ahead, no empty bypass).
// Backpressure: requests throttled by credit (count + outstanding < DEPTH); data_hazard holds the head entry.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mb_if__jump_taken,
  input  logic [31:0] mb_if__jump_target,
  input  logic        data_hazard,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id__valid,
  output logic [31:0] if_id__pc,
  output logic [31:0] if_id__ins,
  output logic        pipe_flush
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];

  logic [CW:0] credit_used;
  logic        req_fire;
  logic        rsp_fire;
  logic        enq;
  logic        deq;

  // Credit counts buffered entries plus requests still in flight, so every response has a slot.
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = rst_n && !mb_if__jump_taken && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = req_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are stale (e.g. from before reset) and are ignored.
  assign rsp_fire = imem_rsp_valid && (outst_q != '0);
  assign enq      = rsp_fire && (drop_q == '0) && !mb_if__jump_taken;

  assign if_id__valid = (count_q != '0) && !mb_if__jump_taken;
  assign if_id__pc    = pc_mem_q[rd_ptr_q];
  assign if_id__ins   = ins_mem_q[rd_ptr_q];
  assign deq          = if_id__valid && !data_hazard;
  assign pipe_flush   = rst_n && mb_if__jump_taken;

  // Next-state for PCs, occupancy, in-flight tracking and pointers; a redirect overrides everything.
  always_comb begin
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    count_d  = count_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (mb_if__jump_taken) begin
      // Everything still in flight after this cycle belongs to the old stream and must be dropped.
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      req_pc_d = mb_if__jump_target;
      rsp_pc_d = mb_if__jump_target;
      outst_d  = rsp_fire ? outst_q - CW'(1) : outst_q;
      drop_d   = outst_d;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   outst_d = outst_q + CW'(1);
        2'b01:   outst_d = outst_q - CW'(1);
        default: outst_d = outst_q;
      endcase
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (req_fire) req_pc_d = req_pc_q + 32'd4;
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; cleared on reset so the head outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (enq) begin
      pc_mem_q[wr_ptr_q]  <= rsp_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  // Memory must never return more words than were requested.
  a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed bench for fetch_queue against a queue-based reference model.
// Latency: memory model answers in order after a configurable 1..4 cycle delay.
// Backpressure: imem_req_ready and data_hazard are driven per scenario.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mb_if__jump_taken = 1'b0;
  logic [31:0] mb_if__jump_target = '0;
  logic        data_hazard = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_id__valid;
  logic [31:0] if_id__pc;
  logic [31:0] if_id__ins;
  logic        pipe_flush;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mb_if__jump_taken  (mb_if__jump_taken),
    .mb_if__jump_target (mb_if__jump_target),
    .data_hazard        (data_hazard),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .if_id__valid       (if_id__valid),
    .if_id__pc          (if_id__pc),
    .if_id__ins         (if_id__ins),
    .pipe_flush         (pipe_flush)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Memory model: in-order pending requests with due cycles.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Reference model: buffered entries, in-flight count, words still to discard, next PCs.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_ins[$];
  int          m_out;
  int          m_drop;
  logic [31:0] m_req;
  logic [31:0] m_rsp;

  logic        e_rv, e_iv, e_fl;
  logic [31:0] e_addr, e_pc, e_ins;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h5a5a_5a5a;
  endfunction

  task automatic model_reset();
    mq_pc.delete();
    mq_ins.delete();
    m_out  = 0;
    m_drop = 0;
    m_req  = RPC;
    m_rsp  = RPC;
    pend_addr.delete();
    pend_due.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mb_if__jump_taken = 1'b0;
    data_hazard = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_due = cyc;
  endtask

  // Present this cycle's memory response and compute expected outputs; called just after negedge.
  task automatic settle();
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    e_rv   = !mb_if__jump_taken && (mq_pc.size() + m_out < DEPTH);
    e_addr = m_req;
    e_iv   = (mq_pc.size() != 0) && !mb_if__jump_taken;
    e_fl   = mb_if__jump_taken;
    e_pc   = '0;
    e_ins  = '0;
    if (e_iv) begin
      e_pc  = mq_pc[0];
      e_ins = mq_ins[0];
    end
    #1;
  endtask

  // Clock the cycle: update the memory model and the reference model, end at the next negedge.
  task automatic advance();
    logic fire;
    logic rsp;
    logic [31:0] rdat;
    fire = imem_req_valid && imem_req_ready;
    rsp  = imem_rsp_valid;
    rdat = imem_rsp_data;
    @(posedge clk);
    if (rsp) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (fire) begin
      int d;
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(d);
      last_due = d;
    end
    if (mb_if__jump_taken) begin
      mq_pc.delete();
      mq_ins.delete();
      if (rsp && m_out > 0) m_out--;
      m_drop = m_out;
      m_req  = mb_if__jump_target;
      m_rsp  = mb_if__jump_target;
    end else begin
      if (e_iv && !data_hazard) begin
        void'(mq_pc.pop_front());
        void'(mq_ins.pop_front());
      end
      if (rsp && m_out > 0) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin
          mq_pc.push_back(m_rsp);
          mq_ins.push_back(rdat);
          m_rsp = m_rsp + 32'd4;
        end
      end
      if (e_rv && imem_req_ready) begin
        m_out++;
        m_req = m_req + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    vectors++;
    if (if_id__valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_if_valid: got %b want 0", if_id__valid);
    end
    vectors++;
    if (pipe_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flush: got %b want 0", pipe_flush);
    end
    vectors++;
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_stream();
    int first_vld;
    first_vld = -1;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL stream c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (first_vld < 0 && if_id__valid) first_vld = i;
      if (i >= 2 && if_id__valid && if_id__pc !== RPC + 32'(4 * (i - 2))) begin
        miscompares++;
        $display("FAIL stream_rate i=%0d: got pc=%h want %h", i, if_id__pc, RPC + 32'(4 * (i - 2)));
      end
      advance();
    end
    if (first_vld != 2) begin
      miscompares++;
      $display("FAIL stream_first_latency: got cycle %0d want 2", first_vld);
    end
    vectors++;
  endtask

  task automatic test_hazard();
    logic [31:0] seen[$];
    do_reset();
    lat_min = 1;
    lat_max = 1;
    data_hazard = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL hazard c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (if_id__valid && if_id__pc !== RPC) begin
        miscompares++;
        $display("FAIL hazard_hold c%0d: got pc=%h want %h", cyc, if_id__pc, RPC);
      end
      if (i == 9 && imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL hazard_credit: got req_valid=%b want 0", imem_req_valid);
      end
      advance();
    end
    data_hazard = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL hazard_rel c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (if_id__valid) seen.push_back(if_id__pc);
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      if (seen.size() <= k || seen[k] !== RPC + 32'(4 * k)) begin
        miscompares++;
        $display("FAIL hazard_order k=%0d: got %h want %h", k, (seen.size() > k) ? seen[k] : 32'hx, RPC + 32'(4 * k));
      end
      vectors++;
    end
  endtask

  task automatic test_redirect_drop();
    logic found;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mb_if__jump_taken  = (i == 3);
      mb_if__jump_target = 32'h200;
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL redirect c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (i == 3 && (pipe_flush !== 1'b1 || imem_req_valid !== 1'b0)) begin
        miscompares++;
        $display("FAIL redirect_flush: got flush=%b req_valid=%b want 1 0", pipe_flush, imem_req_valid);
      end
      if (i > 3 && !found && if_id__valid) begin
        found = 1'b1;
        if (if_id__pc !== 32'h200 || if_id__ins !== word_of(32'h200)) begin
          miscompares++;
          $display("FAIL redirect_first: got pc=%h ins=%h want pc=%h ins=%h",
                   if_id__pc, if_id__ins, 32'h200, word_of(32'h200));
        end
      end
      advance();
    end
    mb_if__jump_taken = 1'b0;
    if (!found) begin
      miscompares++;
      $display("FAIL redirect_timeout: got no valid after redirect, want pc 00000200");
    end
    vectors++;
  endtask

  task automatic test_double_jump();
    logic found;
    logic bad;
    found = 1'b0;
    bad = 1'b0;
    do_reset();
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 18; i++) begin
      mb_if__jump_taken  = (i == 4 || i == 5);
      mb_if__jump_target = (i == 4) ? 32'h300 : 32'h400;
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL dbljump c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (i > 5 && if_id__valid) begin
        if (if_id__pc[31:8] == 24'h3 || if_id__ins !== word_of(if_id__pc)) bad = 1'b1;
        if (!found) begin
          found = 1'b1;
          if (if_id__pc !== 32'h400) begin
            miscompares++;
            $display("FAIL dbljump_first: got pc=%h want 00000400", if_id__pc);
          end
        end
      end
      advance();
    end
    mb_if__jump_taken = 1'b0;
    if (!found || bad) begin
      miscompares++;
      $display("FAIL dbljump_stream: got found=%b stale=%b want found=1 stale=0", found, bad);
    end
    vectors++;
  endtask

  task automatic test_ready_low();
    logic [31:0] held;
    do_reset();
    lat_min = 1;
    lat_max = 2;
    held = '0;
    for (int i = 0; i < 16; i++) begin
      imem_req_ready = !(i >= 3 && i < 8);
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL ready_low c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (i == 3) held = imem_req_addr;
      if (i > 3 && i < 8 && imem_req_addr !== held) begin
        miscompares++;
        $display("FAIL ready_low_addr c%0d: got %h want %h", cyc, imem_req_addr, held);
      end
      if (i == 7 && if_id__valid !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_low_drain: got if_valid=%b want 0", if_id__valid);
      end
      advance();
    end
    imem_req_ready = 1'b1;
  endtask

  task automatic test_wrap_and_async_reset();
    logic [31:0] seen[$];
    logic [31:0] want[3];
    want[0] = 32'hffff_fff8;
    want[1] = 32'hffff_fffc;
    want[2] = 32'h0000_0000;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      mb_if__jump_taken  = (i == 1);
      mb_if__jump_target = 32'hffff_fff8;
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL wrap c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (i > 1 && if_id__valid) seen.push_back(if_id__pc);
      advance();
    end
    mb_if__jump_taken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (seen.size() <= k || seen[k] !== want[k]) begin
        miscompares++;
        $display("FAIL wrap_pc k=%0d: got %h want %h", k, (seen.size() > k) ? seen[k] : 32'hx, want[k]);
      end
      vectors++;
    end
    // Stream is running here; pull reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    if ({imem_req_valid, if_id__valid, pipe_flush} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset: got req=%b if=%b flush=%b want 0 0 0", imem_req_valid, if_id__valid, pipe_flush);
    end
    vectors++;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL restart c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (i == 0 && imem_req_addr !== RPC) begin
        miscompares++;
        $display("FAIL restart_pc: got %h want %h", imem_req_addr, RPC);
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 500; i++) begin
      mb_if__jump_taken  = ($urandom_range(99, 0) < 6);
      mb_if__jump_target = {$urandom_range(32'h3fff_ffff, 0), 2'b00};
      data_hazard        = ($urandom_range(99, 0) < 35);
      imem_req_ready     = ($urandom_range(99, 0) < 75);
      settle();
      if ({imem_req_valid, imem_req_addr, if_id__valid, pipe_flush} !== {e_rv, e_addr, e_iv, e_fl} ||
          (e_iv && {if_id__pc, if_id__ins} !== {e_pc, e_ins})) begin
        miscompares++;
        $display("FAIL random c%0d: got rv=%b a=%h iv=%b pc=%h ins=%h fl=%b want rv=%b a=%h iv=%b pc=%h ins=%h fl=%b",
                 cyc, imem_req_valid, imem_req_addr, if_id__valid, if_id__pc, if_id__ins, pipe_flush,
                 e_rv, e_addr, e_iv, e_pc, e_ins, e_fl);
      end
      vectors++;
      if (if_id__valid && if_id__ins !== word_of(if_id__pc)) begin
        miscompares++;
        $display("FAIL random_pairing c%0d: got ins=%h for pc=%h want %h", cyc, if_id__ins, if_id__pc, word_of(if_id__pc));
      end
      vectors++;
      advance();
    end
    mb_if__jump_taken = 1'b0;
    data_hazard = 1'b0;
    imem_req_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hazard();
    test_redirect_drop();
    test_double_jump();
    test_ready_low();
    test_wrap_and_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
